frame_scheduler: RTL and testbench

- Per-frame sequencer for the render pipeline; a parameterised successor to the hard-wired system FSM.
- After each page flip it runs, in order:
  - position update, every POS_DIV frames;
  - environment draw;
  - sprite queue draw.
- Once an end condition is latched it draws the game-over or you-win overlay into both buffers, then halts.
- Drives the RUN_* strobes to the subsystems and ENG_SEL to the engine mux; adds a per-state watchdog, frame counter and status flags.

---
 rtl/render_pkg.sv | 25 ++
 rtl/sched_watchdog.sv | 32 +++
 rtl/frame_scheduler.sv | 155 +++++++++++++++
 tb/tb_frame_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared render-pipeline types: scheduler states, engine mux and end-state codes
package render_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_POS,
    S_ENV,
    S_SPR,
    S_FDONE,
    S_END_DRAW,
    S_HALT
  } sched_state_t;

  // engine mux select codes
  localparam logic [1:0] ENG_ENV = 2'd0;
  localparam logic [1:0] ENG_SPR = 2'd1;
  localparam logic [1:0] ENG_GO  = 2'd2;
  localparam logic [1:0] ENG_YW  = 2'd3;

  // end-of-game codes
  localparam logic [1:0] END_PLAY = 2'd0;
  localparam logic [1:0] END_GO   = 2'd1;
  localparam logic [1:0] END_WIN  = 2'd2;

endpackage

// File: rtl/sched_watchdog.sv
// rtl/sched_watchdog.sv - per-state cycle counter with terminal-count flag
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the count (state entry)
//   en         : count this cycle (run states)
//   tc         : count has reached TIMEOUT_CYCLES-1 while enabled
module sched_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - per-frame render sequencer: position, environment, sprites, end overlay
//   CLOCK_50, RESET          : clock, async active-low reset
//   PAGE_FLIP                : vertical-blank page swap pulse, starts a frame
//   *_DONE                   : subsystem completion (pulse or level)
//   GAME_OVER, YOU_WIN       : end condition levels
//   RUN_*                    : run strobes, high for the whole state
//   ENG_SEL                  : engine mux select
//   FRAME_COUNT, END_STATE   : completed frames, latched end state
//   TIMEOUT_ERR, OVERRUN     : sticky error flags
module frame_scheduler #(
  parameter int unsigned POS_DIV        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned FC_W           = 16
) (
  input  logic            CLOCK_50,
  input  logic            RESET,
  input  logic            PAGE_FLIP,
  input  logic            POS_UPDATE_DONE,
  input  logic            ENV_DONE,
  input  logic            SPR_DONE,
  input  logic            G_O_DONE,
  input  logic            Y_W_DONE,
  input  logic            GAME_OVER,
  input  logic            YOU_WIN,
  output logic            RUN_POS_UPDATE,
  output logic            RUN_ENV,
  output logic            RUN_SPR,
  output logic            RUN_GAME_OVER,
  output logic            RUN_YOU_WIN,
  output logic [1:0]      ENG_SEL,
  output logic [FC_W-1:0] FRAME_COUNT,
  output logic [1:0]      END_STATE,
  output logic            TIMEOUT_ERR,
  output logic            OVERRUN
);

  import render_pkg::*;

  sched_state_t state, state_next;
  logic         fresh;      // first cycle in the current state
  logic [7:0]   divider;
  logic [1:0]   end_latch;
  logic         end_pass;
  logic         in_run, done_sel, done_ok, tc, adv;

  assign in_run = (state == S_POS) || (state == S_ENV) ||
                  (state == S_SPR) || (state == S_END_DRAW);

  always_comb begin
    done_sel = 1'b0;
    case (state)
      S_POS:      done_sel = POS_UPDATE_DONE;
      S_ENV:      done_sel = ENV_DONE;
      S_SPR:      done_sel = SPR_DONE;
      S_END_DRAW: done_sel = (END_STATE == END_GO) ? G_O_DONE : Y_W_DONE;
      default:    done_sel = 1'b0;
    endcase
  end

  // DONE is ignored on the entry cycle so a level left over from the
  // previous run gets a cycle to drop.
  assign done_ok = in_run && !fresh && done_sel;
  assign adv     = done_ok || tc;

  sched_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk   (CLOCK_50),
    .rst_n (RESET),
    .clr   (state_next != state),
    .en    (in_run),
    .tc    (tc)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_WAIT: begin
        if (PAGE_FLIP) begin
          if (END_STATE != END_PLAY) state_next = S_END_DRAW;
          else if (divider == 8'd0)  state_next = S_POS;
          else                       state_next = S_ENV;
        end
      end
      S_POS:      if (adv) state_next = S_ENV;
      S_ENV:      if (adv) state_next = S_SPR;
      S_SPR:      if (adv) state_next = S_FDONE;
      S_FDONE:    state_next = S_WAIT;
      S_END_DRAW: if (adv) state_next = end_pass ? S_HALT : S_WAIT;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_WAIT;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      state       <= S_WAIT;
      fresh       <= 1'b1;
      divider     <= 8'd0;
      end_latch   <= END_PLAY;
      end_pass    <= 1'b0;
      FRAME_COUNT <= '0;
      END_STATE   <= END_PLAY;
      TIMEOUT_ERR <= 1'b0;
      OVERRUN     <= 1'b0;
    end else begin
      state <= state_next;
      fresh <= (state_next != state);

      if (tc && !done_ok) TIMEOUT_ERR <= 1'b1;

      if (PAGE_FLIP && (in_run || state == S_FDONE)) OVERRUN <= 1'b1;

      // first end condition wins and is held; GAME_OVER beats YOU_WIN
      if (END_STATE == END_PLAY && end_latch == END_PLAY) begin
        if (GAME_OVER)    end_latch <= END_GO;
        else if (YOU_WIN) end_latch <= END_WIN;
      end

      if (state == S_FDONE) begin
        FRAME_COUNT <= FRAME_COUNT + FC_W'(1);
        divider     <= (divider == 8'(POS_DIV - 1)) ? 8'd0 : divider + 8'd1;
        END_STATE   <= end_latch;
      end

      if (state == S_END_DRAW && adv) begin
        FRAME_COUNT <= FRAME_COUNT + FC_W'(1);
        end_pass    <= 1'b1;
      end
    end
  end

  // Moore outputs
  always_comb begin
    RUN_POS_UPDATE = 1'b0;
    RUN_ENV        = 1'b0;
    RUN_SPR        = 1'b0;
    RUN_GAME_OVER  = 1'b0;
    RUN_YOU_WIN    = 1'b0;
    ENG_SEL        = ENG_ENV;
    case (state)
      S_POS: RUN_POS_UPDATE = 1'b1;
      S_ENV: RUN_ENV = 1'b1;
      S_SPR: begin
        RUN_SPR = 1'b1;
        ENG_SEL = ENG_SPR;
      end
      S_END_DRAW: begin
        RUN_GAME_OVER = (END_STATE == END_GO);
        RUN_YOU_WIN   = (END_STATE == END_WIN);
        ENG_SEL       = (END_STATE == END_GO) ? ENG_GO : ENG_YW;
      end
      default: ENG_SEL = ENG_ENV;
    endcase
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - scoreboard bench for frame_scheduler
module tb_frame_scheduler;

  localparam int POS_DIV = 2;
  localparam int TMO     = 16;
  localparam int FC_W    = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic page_flip, pos_done, env_done, spr_done, go_done, yw_done, game_over, you_win;
  logic run_pos, run_env, run_spr, run_go, run_yw;
  logic [1:0] eng_sel, end_state;
  logic [FC_W-1:0] frame_count;
  logic timeout_err, overrun;

  always #5 clk = ~clk;

  frame_scheduler #(.POS_DIV(POS_DIV), .TIMEOUT_CYCLES(TMO), .FC_W(FC_W)) dut (
    .CLOCK_50(clk), .RESET(rst_n), .PAGE_FLIP(page_flip),
    .POS_UPDATE_DONE(pos_done), .ENV_DONE(env_done), .SPR_DONE(spr_done),
    .G_O_DONE(go_done), .Y_W_DONE(yw_done), .GAME_OVER(game_over), .YOU_WIN(you_win),
    .RUN_POS_UPDATE(run_pos), .RUN_ENV(run_env), .RUN_SPR(run_spr),
    .RUN_GAME_OVER(run_go), .RUN_YOU_WIN(run_yw), .ENG_SEL(eng_sel),
    .FRAME_COUNT(frame_count), .END_STATE(end_state),
    .TIMEOUT_ERR(timeout_err), .OVERRUN(overrun)
  );

  typedef struct {
    logic [4:0] run;
    logic [1:0] eng;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // responder controls
  int fixed_dly = 0;
  bit env_level = 0;
  bit spr_mute  = 0;

  // reference model
  int m_frames, m_fc, m_end, m_pend;
  bit m_pass, m_halt;

  function automatic logic [4:0] runv();
    return {run_pos, run_env, run_spr, run_go, run_yw};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // one run phase per flip: what the sequencer must do, from the rules alone
  task automatic model_flip();
    if (m_halt) return;
    if (m_end != 0) begin
      if (m_end == 1) exp_q.push_back('{5'b00010, 2'd2});
      else            exp_q.push_back('{5'b00001, 2'd3});
      m_fc++;
      if (m_pass) m_halt = 1;
      m_pass = 1;
    end else begin
      if (m_frames % POS_DIV == 0) exp_q.push_back('{5'b10000, 2'd0});
      exp_q.push_back('{5'b01000, 2'd0});
      exp_q.push_back('{5'b00100, 2'd1});
      m_frames++;
      m_fc++;
    end
  endtask

  // subsystem model: DONE pulse dly cycles after a RUN rises, or ENV_DONE held
  initial begin
    logic [4:0] prev, cur;
    int age, dly;
    prev = 0; age = 0; dly = 1;
    pos_done = 0; env_done = 0; spr_done = 0; go_done = 0; yw_done = 0;
    forever begin
      @(negedge clk);
      pos_done = 0; env_done = env_level; spr_done = 0; go_done = 0; yw_done = 0;
      cur = runv();
      if (cur != prev) begin
        age = 0;
        dly = (fixed_dly != 0) ? fixed_dly : int'($urandom_range(1, 8));
      end else begin
        age++;
      end
      prev = cur;
      if (cur != 0 && age == dly) begin
        if (cur[4]) pos_done = 1;
        if (cur[3]) env_done = 1;
        if (cur[2] && !spr_mute) spr_done = 1;
        if (cur[1]) go_done = 1;
        if (cur[0]) yw_done = 1;
      end
    end
  end

  // monitor: every new run state is popped against the scoreboard
  logic [4:0] mon_prev = 0;
  int mon_dur = 0;
  always @(negedge clk) begin
    logic [4:0] cur;
    exp_t e;
    cur = runv();
    if (cur != mon_prev) begin
      if (mon_prev != 0 && rst_n) check("run_state_min_len", mon_dur >= 2, 1);
      if (cur != 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_run", cur, 0);
        end else begin
          e = exp_q.pop_front();
          check("run_seq", cur, e.run);
          check("eng_sel", eng_sel, e.eng);
        end
      end
      mon_dur = 1;
    end else begin
      mon_dur++;
    end
    mon_prev = cur;
  end

  task automatic pulse_flip();
    @(negedge clk) page_flip = 1;
    @(negedge clk) page_flip = 0;
  endtask

  task automatic wait_run(input int bitn, input string tag);
    int n = 0;
    logic [4:0] v;
    v = runv();
    while (!v[bitn] && n < 200) begin
      @(negedge clk);
      v = runv();
      n++;
    end
    if (n >= 200) check({tag, "_wait_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || runv() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check({tag, "_idle_timeout"}, 0, 1);
    repeat (3) @(negedge clk);
  endtask

  // mode 0 plain, 1 extra flip during ENV, 2 raise GAME_OVER+YOU_WIN during SPR
  task automatic frame(input int mode);
    model_flip();
    pulse_flip();
    if (mode == 1) begin
      wait_run(3, "ovr");
      pulse_flip();
    end
    if (mode == 2) begin
      wait_run(2, "end");
      game_over = 1;
      you_win   = 1;
      if (m_pend == 0) m_pend = 1;
    end
    wait_idle("frame");
    if (m_end == 0) m_end = m_pend;
    check("frame_count", frame_count, m_fc);
  endtask

  task automatic do_reset();
    rst_n = 0;
    page_flip = 0; game_over = 0; you_win = 0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    m_frames = 0; m_fc = 0; m_end = 0; m_pend = 0; m_pass = 0; m_halt = 0;
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_run"}, runv(), 0);
    check({tag, "_eng"}, eng_sel, 0);
    check({tag, "_fc"}, frame_count, 0);
    check({tag, "_end"}, end_state, 0);
    check({tag, "_tmo"}, timeout_err, 0);
    check({tag, "_ovr"}, overrun, 0);
  endtask

  task automatic end_sequence(input int code);
    check("end_state", end_state, code);
    frame(0);
    frame(0);
    // halted: a further flip must do nothing
    frame(0);
    repeat (20) @(negedge clk);
    check("halt_run", runv(), 0);
    check("halt_eng", eng_sel, 0);
    check("halt_ovr", overrun, 0);
  endtask

  initial begin
    int cnt, k;
    do_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

    // fixed 5-cycle DONE, four frames: POS on frames 0 and 2
    fixed_dly = 5;
    for (int i = 0; i < 4; i++) frame(0);
    check("fc_after_4", frame_count, 4);

    // ENV_DONE held high
    env_level = 1;
    for (int i = 0; i < 2; i++) frame(0);
    env_level = 0;

    // random DONE latencies and flip gaps
    fixed_dly = 0;
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      frame(0);
    end

    // overrun during ENV
    fixed_dly = 5;
    check("ovr_before", overrun, 0);
    frame(1);
    check("ovr_after", overrun, 1);
    frame(0);

    // SPR watchdog
    check("tmo_before", timeout_err, 0);
    spr_mute = 1;
    model_flip();
    pulse_flip();
    wait_run(2, "tmo");
    cnt = 0;
    while (run_spr && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("spr_timeout_len", cnt, TMO);
    wait_idle("tmo");
    spr_mute = 0;
    check("tmo_after", timeout_err, 1);
    check("tmo_fc", frame_count, m_fc);

    // game over (both flags together) after a fresh reset
    do_reset();
    fixed_dly = 0;
    frame(0);
    frame(2);
    end_sequence(1);

    // asynchronous reset in the middle of SPR
    do_reset();
    frame(0);
    model_flip();
    pulse_flip();
    wait_run(2, "arst");
    #2 rst_n = 0;
    #1 check_reset_outputs("async_reset");
    do_reset();

    // random win frame
    k = $urandom_range(1, 3);
    for (int i = 1; i <= k; i++) begin
      if (i == k) begin
        you_win = 1;
        m_pend = 2;
      end
      frame(0);
    end
    end_sequence(2);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
